// File: rtl/reg_write_arbiter_pkg.sv
// Shared sizes, register index names and arbiter FSM encoding for the 16-bit pipeline.
package reg_write_arbiter_pkg;

  localparam int NREG     = 16;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 2;
  localparam int IDX_W    = 4;
  localparam int MAX_WAIT = 8;
  localparam int WAIT_W   = $clog2(MAX_WAIT);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [IDX_W-1:0] SP = 4'd8;
  localparam logic [IDX_W-1:0] IH = 4'd9;
  localparam logic [IDX_W-1:0] T  = 4'd10;
  localparam logic [IDX_W-1:0] RA = 4'd11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FREEZE = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_pending_counter.sv
// Saturating up/down pending counter for one register; o_err pulses when the netted update leaves range.
module reg_pending_counter
  import reg_write_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec1,
  input  logic             i_dec2,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_down;
  logic [SUM_W-1:0] w_net;
  logic             w_under;
  logic             w_over;

  // Increment and both decrements are netted before the range check.
  always_comb begin
    w_up    = SUM_W'(r_cnt) + SUM_W'(i_inc);
    w_down  = SUM_W'(i_dec1) + SUM_W'(i_dec2);
    w_under = (w_up < w_down);
    w_net   = w_up - w_down;
    w_over  = !w_under && (w_net > SUM_W'(CNT_MAX));
    if (w_under) begin
      w_next = '0;
    end else if (w_over) begin
      w_next = CNT_MAX;
    end else begin
      w_next = w_net[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = w_under | w_over;

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter (WB over debug) plus pending-write scoreboard and hazard stall.
// Write port and id_stall are same-cycle; dbg_ack follows the grant by one cycle; stats via REG_WRITE_ARB_STATS_EN.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [IDX_W-1:0]  issue_dst,
  input  logic [IDX_W-1:0]  issue_src1,
  input  logic [IDX_W-1:0]  issue_src2,
  input  logic              issue_src1_used,
  input  logic              issue_src2_used,
  output logic              id_stall,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [IDX_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              kill_valid,
  input  logic [IDX_W-1:0]  kill_dst,
  input  logic              dbg_req,
  input  logic [IDX_W-1:0]  dbg_dst,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending_vec,
  output logic              sb_err,
  output logic [15:0]       stall_cycles,
  output logic [7:0]        dbg_writes
);

  arb_state_t        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_dbg_ack;
  logic              r_sb_err;

  logic [CNT_W-1:0]  w_cnt [NREG];
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec_wb;
  logic [NREG-1:0]   w_dec_kill;
  logic [NREG-1:0]   w_err;
  logic              w_wb_write;
  logic              w_accept;
  logic              w_freeze;
  logic              w_grant;

  assign w_wb_write = wb_valid & wb_we;
  assign w_freeze   = (r_state == FREEZE);
  assign w_accept   = issue_valid & ~id_stall;

  // No bypass: a register retiring this cycle still reads as pending.
  assign id_stall = issue_valid &
                    ((issue_src1_used & (w_cnt[issue_src1] != '0)) |
                     (issue_src2_used & (w_cnt[issue_src2] != '0)) |
                     (issue_we & (w_cnt[issue_dst] == CNT_MAX)) |
                     w_freeze);

  assign w_grant = ((r_state == WAIT) | w_freeze) & dbg_req & ~w_wb_write &
                   (w_cnt[dbg_dst] == '0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
    assign w_inc[gi]      = w_accept & issue_we & (issue_dst == IDX_W'(gi));
    assign w_dec_wb[gi]   = w_wb_write & (wb_dst == IDX_W'(gi));
    assign w_dec_kill[gi] = kill_valid & (kill_dst == IDX_W'(gi));

    reg_pending_counter u_cnt (
      .clk    (clk),
      .rst_n  (rst),
      .i_inc  (w_inc[gi]),
      .i_dec1 (w_dec_wb[gi]),
      .i_dec2 (w_dec_kill[gi]),
      .o_cnt  (w_cnt[gi]),
      .o_err  (w_err[gi])
    );

    assign pending_vec[gi] = (w_cnt[gi] != '0);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_wb_write) begin
      rf_we    = 1'b1;
      rf_waddr = wb_dst;
      rf_wdata = wb_data;
    end else if (w_grant) begin
      rf_we    = 1'b1;
      rf_waddr = dbg_dst;
      rf_wdata = dbg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_dbg_ack  <= 1'b0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (dbg_req) r_state <= WAIT;
        end
        WAIT: begin
          if (!dbg_req) begin
            r_state <= IDLE;
          end else if (w_grant) begin
            r_state   <= ACK;
            r_dbg_ack <= 1'b1;
          end else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            r_state <= FREEZE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        FREEZE: begin
          if (!dbg_req) begin
            r_state <= IDLE;
          end else if (w_grant) begin
            r_state   <= ACK;
            r_dbg_ack <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_err <= 1'b0;
    end else if (|w_err) begin
      r_sb_err <= 1'b1;
    end
  end

  assign dbg_ack = r_dbg_ack;
  assign sb_err  = r_sb_err;

`ifdef REG_WRITE_ARB_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_dbg_writes;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_dbg_writes   <= '0;
    end else begin
      if (id_stall) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_grant)  r_dbg_writes   <= r_dbg_writes + 8'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign dbg_writes   = r_dbg_writes;
`else
  assign stall_cycles = '0;
  assign dbg_writes   = '0;
`endif

endmodule
